// File: rtl/sseg_capture_if.sv
// rtl/sseg_capture_if.sv - seven-segment observer signal bundle (display pins in, decoded frame out)
interface sseg_capture_if;
    logic [3:0]  sseg;
    logic [7:0]  led;
    logic [15:0] num;
    logic        num_valid;
    logic [3:0]  digit_mask;
    logic        seg_err;

    modport master (
        output sseg,
        output led,
        input  num,
        input  num_valid,
        input  digit_mask,
        input  seg_err
    );

    modport slave (
        input  sseg,
        input  led,
        output num,
        output num_valid,
        output digit_mask,
        output seg_err
    );
endinterface

// File: rtl/sseg_capture.sv
// rtl/sseg_capture.sv - multiplexed seven-segment display capture and hex reassembly
// Optional macro SSEG_CAPTURE_CHANGE_ONLY_EN: num_valid pulses only when num changes value.
module sseg_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    sseg_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [11:0]   s_q;
    logic [11:0]   s_prev;
    logic [CW-1:0] stab_cnt;
    logic          fired;
    logic [15:0]   shadow;
    logic [3:0]    mask;
    logic [15:0]   num_q;
    logic          valid_q;
    logic          err_q;
    logic          first_q;

    logic          cap;
    logic [3:0]    sel;
    logic [3:0]    slot;
    logic          sel_ok;
    logic          hit;
    logic [3:0]    nib;
    logic          full;
    logic [3:0]    mask_base;
    logic          pulse_ok;

    // The captured pattern is taken from s_prev: when a pattern is held exactly
    // STABLE_CYCLES cycles, s_q has already moved on in the capture cycle.
    always_comb begin
        cap    = (stab_cnt == CNT_MAX) && !fired;
        sel    = ~s_prev[11:8];
        slot   = {sel[0], sel[1], sel[2], sel[3]};
        sel_ok = $onehot(sel);
        hit    = 1'b1;
        nib    = 4'h0;
        case (s_prev[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: hit = 1'b0;
        endcase
        full      = (mask == 4'hF);
        mask_base = full ? 4'h0 : mask;
`ifdef SSEG_CAPTURE_CHANGE_ONLY_EN
        pulse_ok  = first_q || (shadow != num_q);
`else
        pulse_ok  = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= '1;
            s_prev   <= '1;
            stab_cnt <= '0;
            fired    <= 1'b0;
            shadow   <= '0;
            mask     <= '0;
            num_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            s_q     <= {bus.sseg, bus.led};
            s_prev  <= s_q;
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (s_q != s_prev) begin
                stab_cnt <= '0;
                fired    <= 1'b0;
            end else begin
                if (stab_cnt != CNT_MAX)
                    stab_cnt <= stab_cnt + 1'b1;
                if (cap)
                    fired <= 1'b1;
            end

            if (full) begin
                num_q   <= shadow;
                valid_q <= pulse_ok;
                first_q <= 1'b0;
            end

            if (cap && sel_ok && hit) begin
                mask <= mask_base | slot;
                for (int i = 0; i < 4; i++)
                    if (slot[i])
                        shadow[i*4 +: 4] <= nib;
            end else begin
                mask <= mask_base;
            end

            if (cap && sel_ok && !hit)
                err_q <= 1'b1;
        end
    end

    assign bus.num        = num_q;
    assign bus.num_valid  = valid_q;
    assign bus.digit_mask = mask;
    assign bus.seg_err    = err_q;
endmodule

// File: tb/tb_sseg_capture.sv
// tb/tb_sseg_capture.sv - directed table-driven bench for sseg_capture
module tb_sseg_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_capture_if bus ();

    sseg_capture #(.STABLE_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r;
        logic [3:0]  sseg;
        logic [7:0]  led;
        int          hold;
        logic [3:0]  mask;
        logic [15:0] num;
        int          nvalid;
        int          nerr;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;

`ifdef SSEG_CAPTURE_CHANGE_ONLY_EN
    localparam int REPEAT_PULSES = 0;
`else
    localparam int REPEAT_PULSES = 1;
`endif

    always @(negedge clk) begin
        if (!rst) begin
            valid_cnt += int'(bus.num_valid);
            err_cnt   += int'(bus.seg_err);
        end
    end

    function automatic logic [7:0] seg(input int n, input logic dp = 1'b1);
        logic [6:0] c;
        case (n)
            0: c = 7'h40;  1: c = 7'h79;  2: c = 7'h24;  3: c = 7'h30;
            4: c = 7'h19;  5: c = 7'h12;  6: c = 7'h02;  7: c = 7'h78;
            8: c = 7'h00;  9: c = 7'h10;  10: c = 7'h08; 11: c = 7'h03;
            12: c = 7'h46; 13: c = 7'h21; 14: c = 7'h06; default: c = 7'h0E;
        endcase
        return {dp, c};
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [7:0] l,
                                input int h, input logic [3:0] m, input logic [15:0] n,
                                input int nv, input int ne);
        vec_t v;
        v.r = r; v.sseg = s; v.led = l; v.hold = h;
        v.mask = m; v.num = n; v.nvalid = nv; v.nerr = ne;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [7:0] l, input int h);
        bus.sseg = s;
        bus.led  = l;
        repeat (h) @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        int v0, e0;
        string tag;
        v0 = valid_cnt;
        e0 = err_cnt;
        rst = v.r;
        drive(v.sseg, v.led, v.hold);
        tag = $sformatf("row%0d", idx);
        chk({tag, " digit_mask"}, int'(bus.digit_mask), int'(v.mask));
        chk({tag, " num"}, int'(bus.num), int'(v.num));
        chk({tag, " num_valid pulses"}, valid_cnt - v0, v.nvalid);
        chk({tag, " seg_err pulses"}, err_cnt - e0, v.nerr);
        rst = 1'b0;
    endtask

    initial begin
        int k_mask, k_valid, k_clr;

        // 1234 in driver order
        vecs.push_back(mk(0, 4'hE, seg(1), 40, 4'h8, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(2), 40, 4'hC, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(3), 40, 4'hE, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'h7, seg(4), 40, 4'h0, 16'h1234, 1, 0));
        // second digit too short, then recaptured
        vecs.push_back(mk(0, 4'hE, seg(5), 40, 4'h8, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(6), 10, 4'h8, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(7), 40, 4'hA, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 4'h7, seg(8), 40, 4'hB, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(6), 40, 4'h0, 16'h5678, 1, 0));
        // all segments off: undecodable
        vecs.push_back(mk(0, 4'hD, 8'h7F, 40, 4'h0, 16'h5678, 0, 1));
        // blanking and a two-hot select are ignored; ABCD with gaps
        vecs.push_back(mk(0, 4'hF, 8'hFF, 20, 4'h0, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hC, seg(8), 40, 4'h0, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hE, seg(10), 40, 4'h8, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hF, 8'hFF, 20, 4'h8, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(11), 40, 4'hC, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hF, 8'hFF, 20, 4'hC, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(12), 40, 4'hE, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'hF, 8'hFF, 20, 4'hE, 16'h5678, 0, 0));
        vecs.push_back(mk(0, 4'h7, seg(13), 40, 4'h0, 16'hABCD, 1, 0));
        // reverse scan F00D with decimal point lit, then a partial frame and reset
        vecs.push_back(mk(0, 4'h7, seg(13, 1'b0), 40, 4'h1, 16'hABCD, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(0, 1'b0), 40, 4'h3, 16'hABCD, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(0, 1'b0), 40, 4'h7, 16'hABCD, 0, 0));
        vecs.push_back(mk(0, 4'hE, seg(15, 1'b0), 40, 4'h0, 16'hF00D, 1, 0));
        vecs.push_back(mk(0, 4'h7, seg(1), 40, 4'h1, 16'hF00D, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(2), 40, 4'h3, 16'hF00D, 0, 0));
        vecs.push_back(mk(1, 4'hF, 8'hFF, 3, 4'h0, 16'h0000, 0, 0));
        // BEEF twice
        vecs.push_back(mk(0, 4'hE, seg(11), 40, 4'h8, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(14), 40, 4'hC, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(14), 40, 4'hE, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 4'h7, seg(15), 40, 4'h0, 16'hBEEF, 1, 0));
        vecs.push_back(mk(0, 4'hE, seg(11), 40, 4'h8, 16'hBEEF, 0, 0));
        vecs.push_back(mk(0, 4'hD, seg(14), 40, 4'hC, 16'hBEEF, 0, 0));
        vecs.push_back(mk(0, 4'hB, seg(14), 40, 4'hE, 16'hBEEF, 0, 0));
        vecs.push_back(mk(0, 4'h7, seg(15), 40, 4'h0, 16'hBEEF, REPEAT_PULSES, 0));

        bus.sseg = 4'hF;
        bus.led  = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset num", int'(bus.num), 0);
        chk("reset digit_mask", int'(bus.digit_mask), 0);
        chk("reset num_valid", int'(bus.num_valid), 0);
        chk("reset seg_err", int'(bus.seg_err), 0);
        rst = 1'b0;

        foreach (vecs[i]) apply(i, vecs[i]);

        // hold-length boundary: 15 cycles is not enough, 16 is
        rst = 1'b1;
        drive(4'hF, 8'hFF, 3);
        rst = 1'b0;
        drive(4'hE, seg(5), 15);
        drive(4'hF, 8'hFF, 30);
        chk("hold15 digit_mask", int'(bus.digit_mask), 0);
        drive(4'hE, seg(5), 16);
        drive(4'hF, 8'hFF, 30);
        chk("hold16 digit_mask", int'(bus.digit_mask), 4'h8);

        // capture and completion latency
        k_mask = -1;
        bus.sseg = 4'hD;
        bus.led  = seg(2);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k_mask < 0 && bus.digit_mask == 4'hC) k_mask = k;
        end
        chk("digit capture latency", k_mask, 17);
        drive(4'hB, seg(3), 40);
        k_mask = -1; k_valid = -1; k_clr = -1;
        bus.sseg = 4'h7;
        bus.led  = seg(4);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k_mask < 0 && bus.digit_mask == 4'hF) k_mask = k;
            if (k_mask >= 0 && k_clr < 0 && bus.digit_mask == 4'h0) k_clr = k;
            if (k_valid < 0 && bus.num_valid) k_valid = k;
        end
        chk("full mask cycle", k_mask, 17);
        chk("mask clear cycle", k_clr, 18);
        chk("num_valid cycle", k_valid, 18);
        chk("latency frame num", int'(bus.num), 16'h5234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
